vga_test_pattern: RTL

- Sits directly downstream of the VGA sync pulse generator.
- Consumes its raw H/V sync levels, which are high during the active region and low during blanking.
- Recovers column/row counters locked to those levels and generates porch-correct, active-low output sync pulses.
- Drives a selectable test pattern on RGB, aligned to the output syncs; this is the last stage before the DAC/pins.

---
 rtl/vga_test_pattern.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_test_pattern.sv
// Final video stage: recovers column/row counters from upstream sync levels and drives porched syncs plus a test pattern.
// Optional build macro VGA_GRID_OVERLAY_EN adds a white 64-pixel grid over patterns 1..6.
`timescale 1ns/1ps

module vga_test_pattern #(
    parameter int TOTAL_COLS    = 800,
    parameter int TOTAL_ROWS    = 525,
    parameter int ACTIVE_COLS   = 640,
    parameter int ACTIVE_ROWS   = 480,
    parameter int H_FRONT_PORCH = 18,
    parameter int H_BACK_PORCH  = 50,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_BACK_PORCH  = 33,
    parameter int VIDEO_WIDTH   = 3
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   I_H_Sync,
    input  logic                   I_V_Sync,
    input  logic [3:0]             I_Pattern,
    output logic [9:0]             O_Col_Count,
    output logic [9:0]             O_Row_Count,
    output logic                   O_H_Sync,
    output logic                   O_V_Sync,
    output logic                   O_Active,
    output logic [VIDEO_WIDTH-1:0] O_Red,
    output logic [VIDEO_WIDTH-1:0] O_Grn,
    output logic [VIDEO_WIDTH-1:0] O_Blu
);

    localparam logic [0:0] ST_UNLOCKED = 1'b0;
    localparam logic [0:0] ST_LOCKED   = 1'b1;

    localparam logic [9:0] COL_LAST    = 10'(TOTAL_COLS - 1);
    localparam logic [9:0] ROW_LAST    = 10'(TOTAL_ROWS - 1);
    localparam logic [9:0] ACT_COLS    = 10'(ACTIVE_COLS);
    localparam logic [9:0] ACT_ROWS    = 10'(ACTIVE_ROWS);
    localparam logic [9:0] LAST_ACOL   = 10'(ACTIVE_COLS - 1);
    localparam logic [9:0] LAST_AROW   = 10'(ACTIVE_ROWS - 1);
    localparam logic [9:0] HS_START    = 10'(ACTIVE_COLS + H_FRONT_PORCH);
    localparam logic [9:0] HS_END      = 10'(TOTAL_COLS - H_BACK_PORCH);
    localparam logic [9:0] VS_START    = 10'(ACTIVE_ROWS + V_FRONT_PORCH);
    localparam logic [9:0] VS_END      = 10'(TOTAL_ROWS - V_BACK_PORCH);
    localparam logic [9:0] BAR_WIDTH   = 10'(ACTIVE_COLS / 8);
    localparam logic [VIDEO_WIDTH-1:0] FULL = '1;

    // Edge detection: input register, previous-value register, registered rise flag.
    logic h_cur_reg, h_prev_reg, h_rise_reg;
    logic v_cur_reg, v_prev_reg, v_rise_reg;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            h_cur_reg  <= 1'b0;
            h_prev_reg <= 1'b0;
            h_rise_reg <= 1'b0;
            v_cur_reg  <= 1'b0;
            v_prev_reg <= 1'b0;
            v_rise_reg <= 1'b0;
        end else begin
            h_cur_reg  <= I_H_Sync;
            h_prev_reg <= h_cur_reg;
            h_rise_reg <= h_cur_reg & ~h_prev_reg;
            v_cur_reg  <= I_V_Sync;
            v_prev_reg <= v_cur_reg;
            v_rise_reg <= v_cur_reg & ~v_prev_reg;
        end
    end

    // Stage 1: recovered counters, lock state and latched pattern.
    logic [9:0] col_reg, col_next;
    logic [9:0] row_reg, row_next;
    logic [0:0] state_reg, state_next;
    logic [3:0] pattern_reg, pattern_next;
    logic [9:0] row_inc;

    assign row_inc = (row_reg == ROW_LAST) ? 10'd0 : row_reg + 10'd1;

    always_comb begin
        col_next     = col_reg;
        row_next     = row_reg;
        state_next   = state_reg;
        pattern_next = pattern_reg;
        if (v_rise_reg) begin
            col_next     = 10'd0;
            row_next     = 10'd0;
            state_next   = ST_LOCKED;
            pattern_next = I_Pattern;
        end else if (state_reg == ST_LOCKED) begin
            // An H edge and the natural line wrap both start a new line; only one may win.
            if (h_rise_reg || col_reg == COL_LAST) begin
                col_next = 10'd0;
                row_next = row_inc;
            end else begin
                col_next = col_reg + 10'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            col_reg     <= 10'd0;
            row_reg     <= 10'd0;
            state_reg   <= ST_UNLOCKED;
            pattern_reg <= 4'd0;
        end else begin
            col_reg     <= col_next;
            row_reg     <= row_next;
            state_reg   <= state_next;
            pattern_reg <= pattern_next;
        end
    end

    assign O_Col_Count = col_reg;
    assign O_Row_Count = row_reg;

    // Stage 2 decode, computed from the stage-1 position.
    logic                   locked;
    logic                   visible;
    logic                   hs_pulse;
    logic                   vs_pulse;
    logic [2:0]             bar;
    logic                   on_border;
    logic [VIDEO_WIDTH-1:0] red_next, grn_next, blu_next;

    assign locked    = (state_reg == ST_LOCKED);
    assign visible   = locked && (col_reg < ACT_COLS) && (row_reg < ACT_ROWS);
    assign hs_pulse  = locked && (col_reg >= HS_START) && (col_reg < HS_END);
    assign vs_pulse  = locked && (row_reg >= VS_START) && (row_reg < VS_END);
    assign bar       = 3'(col_reg / BAR_WIDTH);
    assign on_border = (col_reg == 10'd0) || (col_reg == LAST_ACOL) ||
                       (row_reg == 10'd0) || (row_reg == LAST_AROW);

    always_comb begin
        red_next = '0;
        grn_next = '0;
        blu_next = '0;
        case (pattern_reg)
            4'd1: red_next = FULL;
            4'd2: grn_next = FULL;
            4'd3: blu_next = FULL;
            4'd4: begin
                if (col_reg[5] ^ row_reg[5]) begin
                    red_next = FULL;
                    grn_next = FULL;
                    blu_next = FULL;
                end
            end
            4'd5: begin
                red_next = {VIDEO_WIDTH{bar[2]}};
                grn_next = {VIDEO_WIDTH{bar[1]}};
                blu_next = {VIDEO_WIDTH{bar[0]}};
            end
            4'd6: begin
                if (on_border) begin
                    red_next = FULL;
                    grn_next = FULL;
                    blu_next = FULL;
                end
            end
            default: begin
                red_next = '0;
                grn_next = '0;
                blu_next = '0;
            end
        endcase
`ifdef VGA_GRID_OVERLAY_EN
        if ((pattern_reg >= 4'd1) && (pattern_reg <= 4'd6) &&
            ((col_reg[5:0] == 6'd0) || (row_reg[5:0] == 6'd0))) begin
            red_next = FULL;
            grn_next = FULL;
            blu_next = FULL;
        end
`else
`endif
        if (!visible) begin
            red_next = '0;
            grn_next = '0;
            blu_next = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            O_H_Sync <= 1'b1;
            O_V_Sync <= 1'b1;
            O_Active <= 1'b0;
            O_Red    <= '0;
            O_Grn    <= '0;
            O_Blu    <= '0;
        end else begin
            O_H_Sync <= ~hs_pulse;
            O_V_Sync <= ~vs_pulse;
            O_Active <= visible;
            O_Red    <= red_next;
            O_Grn    <= grn_next;
            O_Blu    <= blu_next;
        end
    end

endmodule
